// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg: shared FSM state encodings, BCD digit limits and the hh:mm time type
//   Exports: DIGIT_W, hour/minute digit limits, ring_state_t, bcd_time_t
package alarm_clock_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] HR_MS_MAX  = 4'd2;
    localparam logic [DIGIT_W-1:0] HR_LS_MAX  = 4'd3;
    localparam logic [DIGIT_W-1:0] MIN_MS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] MIN_LS_MAX = 4'd9;
    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZING = 2'd3
    } ring_state_t;
    typedef struct packed {
        logic [DIGIT_W-1:0] ms_hr;
        logic [DIGIT_W-1:0] ls_hr;
        logic [DIGIT_W-1:0] ms_min;
        logic [DIGIT_W-1:0] ls_min;
    } bcd_time_t;
endpackage

// File: rtl/bcd_time_adder.sv
// bcd_time_adder: combinational hh:mm BCD time plus 0-9 minutes, wrapping 23:59 -> 00:00
//   base    in  : BCD time, 24-hour format
//   minutes in  : minutes to add, 0-9
//   sum     out : base + minutes, BCD
module bcd_time_adder
    import alarm_clock_pkg::*;
(
    input  bcd_time_t          base,
    input  logic [DIGIT_W-1:0] minutes,
    output bcd_time_t          sum
);
    logic [DIGIT_W:0] ls_raw;
    logic ls_carry, ms_carry, hr_carry, day_wrap;
    always_comb begin
        ls_raw     = {1'b0, base.ls_min} + {1'b0, minutes};
        ls_carry   = ls_raw > {1'b0, MIN_LS_MAX};
        ms_carry   = ls_carry && base.ms_min == MIN_MS_MAX;
        hr_carry   = ms_carry && base.ls_hr == MIN_LS_MAX;
        day_wrap   = ms_carry && base.ms_hr == HR_MS_MAX && base.ls_hr == HR_LS_MAX;
        sum.ls_min = ls_carry ? 4'(ls_raw - 5'd10) : ls_raw[DIGIT_W-1:0];
        sum.ms_min = ms_carry ? '0 : base.ms_min + {3'b0, ls_carry};
        sum.ls_hr  = (day_wrap || hr_carry) ? '0 : base.ls_hr + {3'b0, ms_carry};
        sum.ms_hr  = day_wrap ? '0 : base.ms_hr + {3'b0, hr_carry};
    end
endmodule

// File: rtl/alarm_ring_controller.sv
// alarm_ring_controller: alarm ring sequencer with snooze, ring timeout and snooze limit
//   clock, reset (async, active-high), one_second tick
//   current_time_*, alarm_time_* : BCD hh:mm digits
//   alarm_enable, snooze_button, stop_button : level inputs, buttons act on rising edge
//   alarm_sound, snooze_active, snooze_count, ring_state : registered status outputs
module alarm_ring_controller
    import alarm_clock_pkg::*;
#(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               one_second,
    input  logic [DIGIT_W-1:0] current_time_ms_hr,
    input  logic [DIGIT_W-1:0] current_time_ls_hr,
    input  logic [DIGIT_W-1:0] current_time_ms_min,
    input  logic [DIGIT_W-1:0] current_time_ls_min,
    input  logic [DIGIT_W-1:0] alarm_time_ms_hr,
    input  logic [DIGIT_W-1:0] alarm_time_ls_hr,
    input  logic [DIGIT_W-1:0] alarm_time_ms_min,
    input  logic [DIGIT_W-1:0] alarm_time_ls_min,
    input  logic               alarm_enable,
    input  logic               snooze_button,
    input  logic               stop_button,
    output logic               alarm_sound,
    output logic               snooze_active,
    output logic [2:0]         snooze_count,
    output logic [1:0]         ring_state
);
    ring_state_t state;
    bcd_time_t   now, alarm_at, target, snooze_sum;
    logic [7:0]  ring_cnt;
    logic        a_match, a_match_q, s_match, snooze_q, stop_q, trigger, snooze_edge, stop_edge;

    assign now         = '{current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min};
    assign alarm_at    = '{alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min};
    assign a_match     = now == alarm_at;
    assign s_match     = now == target;
    // Edge-based trigger so a stopped alarm stays quiet for the rest of its minute.
    assign trigger     = a_match && !a_match_q;
    assign snooze_edge = snooze_button && !snooze_q;
    assign stop_edge   = stop_button && !stop_q;
    assign ring_state  = state;

    bcd_time_adder u_adder (
        .base    (now),
        .minutes (4'(SNOOZE_MIN)),
        .sum     (snooze_sum)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= DISARMED;
            alarm_sound   <= 1'b0;
            snooze_active <= 1'b0;
            snooze_count  <= '0;
            ring_cnt      <= '0;
            target        <= '0;
            snooze_q      <= 1'b0;
            stop_q        <= 1'b0;
            // Time and alarm both come out of reset at 00:00; start "already matched".
            a_match_q     <= 1'b1;
        end else begin
            a_match_q <= a_match;
            snooze_q  <= snooze_button;
            stop_q    <= stop_button;
            if (state != DISARMED && !alarm_enable) begin
                state         <= DISARMED;
                alarm_sound   <= 1'b0;
                snooze_active <= 1'b0;
                snooze_count  <= '0;
            end else begin
                case (state)
                    DISARMED: if (alarm_enable) state <= ARMED;
                    ARMED: if (trigger) begin
                        state       <= RINGING;
                        alarm_sound <= 1'b1;
                        ring_cnt    <= '0;
                    end
                    RINGING: begin
                        if (stop_edge) begin
                            state        <= ARMED;
                            alarm_sound  <= 1'b0;
                            snooze_count <= '0;
                        end else if (snooze_edge && snooze_count < 3'(MAX_SNOOZE)) begin
                            state         <= SNOOZING;
                            alarm_sound   <= 1'b0;
                            snooze_active <= 1'b1;
                            snooze_count  <= snooze_count + 3'd1;
                            target        <= snooze_sum;
                        end else if (one_second) begin
                            if (ring_cnt == 8'(RING_TIMEOUT_S - 1)) begin
                                state        <= ARMED;
                                alarm_sound  <= 1'b0;
                                snooze_count <= '0;
                            end else begin
                                ring_cnt <= ring_cnt + 8'd1;
                            end
                        end
                    end
                    SNOOZING: begin
                        if (stop_edge) begin
                            state         <= ARMED;
                            snooze_active <= 1'b0;
                            snooze_count  <= '0;
                        end else if (s_match) begin
                            state         <= RINGING;
                            snooze_active <= 1'b0;
                            alarm_sound   <= 1'b1;
                            ring_cnt      <= '0;
                        end
                    end
                    default: state <= DISARMED;
                endcase
            end
        end
    end
endmodule

// File: doc/alarm_ring_controller.md
# alarm_ring_controller

Sequences the audible alarm of the digital alarm clock. It compares the running time against the stored alarm time and drives `alarm_sound`. It also implements snooze with a BCD-computed re-ring time, a ring timeout, and a snooze limit. It sits between the time counter / alarm register outputs and the LCD driver's sound input, and replaces the bare comparator path.

## Interface
Parameters:
- `SNOOZE_MIN`, default 5: snooze length in minutes; legal range 1–9.
- `RING_TIMEOUT_S`, default 60: number of `one_second` pulses before ringing stops automatically; legal range 1–255.
- `MAX_SNOOZE`, default 3: number of snoozes allowed per alarm event; legal range 1–7.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `one_second` in 1: single-cycle tick from the timing generator.
- `current_time_ms_hr`, `current_time_ls_hr`, `current_time_ms_min`, `current_time_ls_min` in 4 each: BCD running time, 24-hour format.
- `alarm_time_ms_hr`, `alarm_time_ls_hr`, `alarm_time_ms_min`, `alarm_time_ls_min` in 4 each: BCD alarm time.
- `alarm_enable` in 1: level; 0 disarms the block.
- `snooze_button` in 1: synchronous level; the block acts on its rising edge.
- `stop_button` in 1: synchronous level; the block acts on its rising edge.
- `alarm_sound` out 1: high while ringing.
- `snooze_active` out 1: high while waiting for the snooze time.
- `snooze_count` out 3: snoozes used in the current alarm event.
- `ring_state` out 2: current FSM state, for display and debug.

## Operation
- States and encodings: DISARMED=0, ARMED=1, RINGING=2, SNOOZING=3.
- Match signals:
  - `a_match`: all four current-time digits equal the alarm digits.
  - `s_match`: current time equals the snooze target register.
- Alarm trigger is edge-based. `a_match_q` is registered every cycle in every state, and the trigger is `a_match && !a_match_q`. As a result:
  - Stopping the alarm within the matching minute does not re-trigger it.
  - Enabling the alarm mid-minute does not trigger it.
- Transitions, in priority order within each state:
  - Any state except DISARMED, with `alarm_enable`=0 → DISARMED. Snooze count is cleared.
  - DISARMED, with `alarm_enable`=1 → ARMED.
  - ARMED, on trigger → RINGING. Ring counter is cleared.
  - RINGING, on stop edge → ARMED. Snooze count is cleared.
  - RINGING, on snooze edge with `snooze_count` < `MAX_SNOOZE` → SNOOZING. Then `snooze_count`++, and the target is loaded with current time + `SNOOZE_MIN`.
  - RINGING, on snooze edge at the snooze limit: the edge is ignored and ringing continues.
  - RINGING, on the `one_second` pulse that brings the ring counter to `RING_TIMEOUT_S` → ARMED. Snooze count is cleared.
  - SNOOZING, on stop edge → ARMED. Snooze count is cleared.
  - SNOOZING, on `s_match` → RINGING. Ring counter is cleared.
- Snooze target arithmetic is BCD:
  - The minute digit adds with carry: ls_min wraps 9→0 into ms_min, and ms_min wraps 5→0 into the hour.
  - The hour wraps 23→00.
  - Example: 23:58 + 5 → 00:03.
- Simultaneous events within RINGING: stop beats snooze, and snooze beats timeout.
- Outputs:
  - `alarm_sound` = (state == RINGING).
  - `snooze_active` = (state == SNOOZING).
  - All outputs are registered; none depends combinationally on inputs.

## Timing
- Reset values:
  - State = DISARMED.
  - `alarm_sound`=0, `snooze_active`=0, `snooze_count`=0, `ring_state`=0.
  - Ring counter = 0, snooze target = 00:00, button edge registers = 0.
  - `a_match_q`=1. This prevents a spurious ring, because the time and alarm registers both reset to 00:00.
- Trigger latency: with the match edge sampled at cycle N, `alarm_sound` goes high at N+1.
- Stop/snooze latency: a button rising edge seen at cycle N drops `alarm_sound` at N+1.
- Timeout: `alarm_sound` falls on the cycle after the `RING_TIMEOUT_S`th `one_second` pulse.
- Reset asserted mid-ring forces DISARMED immediately (asynchronous). After release, the block reaches ARMED one cycle later if `alarm_enable`=1.
- A button held high counts as one event only.

## Structure
- Shared package `alarm_clock_pkg` holds:
  - FSM state encodings.
  - The BCD digit width (4).
  - Hour/minute digit limits: 2/3 for the hour digits, 5/9 for the minute digits.
- Sub-module `bcd_time_adder`: adds 0–9 minutes to an hh:mm BCD time, with wrap. It is combinational and is reusable by the counter.
- The ring counter is 8 bits.

## Test plan
- Alarm 07:30, enable=1, time steps 07:29→07:30 → `alarm_sound`=1 one cycle after the match. After 60 `one_second` pulses it returns to 0, and state=ARMED.
- Ringing at 07:30, snooze edge → `snooze_active`=1, `snooze_count`=1. Time reaches 07:35 → rings again.
- Ringing at 23:58, snooze edge → target 00:03. Ringing resumes at 00:03 after the day wrap.
- Three snoozes, then a fourth snooze edge → the edge is ignored and `alarm_sound` stays 1. A stop edge → ARMED, `snooze_count`=0, with no re-ring within 07:30.
- Release reset with the time and alarm both at 00:00 and enable=1 → no ring. Reset asserted mid-ring → `alarm_sound`=0 immediately.
- Stop and snooze edges in the same cycle → ARMED. Enable dropped while SNOOZING → DISARMED, and no ring at the target time.
